// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative, multi-word-block instruction cache with LRU replacement and a block refill FSM.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int WOFF = $clog2(BLKWORDS);
  localparam int IW   = $clog2(SETS);
  localparam int TW   = 30 - WOFF - IW;
  localparam int CW   = (BLKWORDS > 1) ? WOFF : 1;
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t          state_q, state_d;
  logic            valid_q [SETS][WAYS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS][BLKWORDS];
  logic [2:0]      lru_q   [SETS];
  logic [31:0]     buf_q   [BLKWORDS];
  logic [31:0]     line    [BLKWORDS];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;

  logic [29:0]     req_w, fill_w;
  logic [IW-1:0]   req_idx, fill_idx;
  logic [TW-1:0]   req_tag, fill_tag;
  logic [CW-1:0]   req_off;
  logic [WAYS-1:0] hit_vec;
  logic [WB-1:0]   hit_way, victim;
  logic            lookup_hit, fill;

  // Victim from the per-set LRU state: one bit for 2 ways, a 3-bit tree for 4 ways.
  function automatic logic [1:0] lru_victim(input logic [2:0] s);
    return (WAYS == 4) ? (s[0] ? {1'b1, s[2]} : {1'b0, s[1]}) :
           (WAYS == 2) ? {1'b0, s[0]} : 2'b00;
  endfunction

  // LRU state after touching way w: every tree node on the path points away from w.
  function automatic logic [2:0] lru_touch(input logic [2:0] s, input logic [1:0] w);
    return (WAYS == 4) ? (w[1] ? {~w[0], s[1], 1'b0} : {s[2], ~w[0], 1'b1}) :
           (WAYS == 2) ? {2'b00, ~w[0]} : 3'b000;
  endfunction

  assign req_w    = imemaddr[31:2];
  assign fill_w   = addr_q[31:2];
  assign req_off  = CW'(req_w & 30'(BLKWORDS - 1));
  assign req_idx  = IW'(req_w >> WOFF);
  assign fill_idx = IW'(fill_w >> WOFF);
  assign req_tag  = TW'(req_w >> (WOFF + IW));
  assign fill_tag = TW'(fill_w >> (WOFF + IW));

  // Tag compare across the indexed set; the descending scan yields the lowest hitting way.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      hit_way    = hit_vec[w] ? WB'(w) : hit_way;
    end
  end

  // Refill victim: lowest invalid way if any, otherwise the LRU way.
  always_comb begin
    victim = WB'(lru_victim(lru_q[fill_idx]));
    for (int w = WAYS - 1; w >= 0; w--) victim = !valid_q[fill_idx][w] ? WB'(w) : victim;
  end

  // Completed block: buffered words plus the word arriving on this edge.
  always_comb begin
    for (int b = 0; b < BLKWORDS; b++) line[b] = (CW'(b) == cnt_q) ? iload : buf_q[b];
  end

  assign lookup_hit = (state_q == IDLE) && imemREN && |hit_vec;
  assign fill       = (state_q == REFILL) && !iwait && (cnt_q == CW'(BLKWORDS - 1));

  // Refill FSM next state: a miss latches the block base, each accepted word advances the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (state_q == IDLE) begin
      if (imemREN && !(|hit_vec)) begin
        state_d = REFILL;
        cnt_d   = '0;
        addr_d  = imemaddr & ~32'(4 * BLKWORDS - 1);
      end
    end else if (!iwait) begin
      cnt_d   = fill ? '0 : cnt_q + CW'(1);
      state_d = fill ? IDLE : REFILL;
    end
  end

  assign ihit     = nRST && lookup_hit;
  assign iREN     = nRST && (state_q == REFILL);
  assign iaddr    = iREN ? addr_q + (32'(cnt_q) << 2) : '0;
  assign imemload = nRST ? data_q[req_idx][ihit ? hit_way : '0][req_off] : '0;

  // State, line buffer, LRU and array updates; data is cleared on reset so imemload is never X.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      for (int b = 0; b < BLKWORDS; b++) buf_q[b] <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          for (int b = 0; b < BLKWORDS; b++) data_q[s][w][b] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (state_q == REFILL && !iwait) buf_q[cnt_q] <= iload;
      if (lookup_hit) lru_q[req_idx] <= lru_touch(lru_q[req_idx], 2'(hit_way));
      if (fill) begin
        valid_q[fill_idx][victim] <= 1'b1;
        tag_q[fill_idx][victim]   <= fill_tag;
        for (int b = 0; b < BLKWORDS; b++) data_q[fill_idx][victim][b] <= line[b];
        lru_q[fill_idx] <= lru_touch(lru_q[fill_idx], 2'(victim));
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Free-running hit and miss counters that wrap at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_q + 32'(ihit);
      miss_count_q <= miss_count_q + 32'(state_q == IDLE && state_d == REFILL);
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  a_onehot_hit: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(hit_vec));
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised instruction cache; successor to the direct-mapped, one-word-per-line icache.
- N-way set-associative with multi-word blocks and LRU replacement.
- A refill FSM fetches a whole block from the memory side on a miss.
- Sits between the datapath fetch port and the memory controller's instruction channel; read-only, no write-back.

Parameters:
- SETS, 8, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, 1 to 4.
- BLKWORDS, 2, 32-bit words per block; power of 2, 1 to 4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; synchronous, active-low, sampled on the CLK rising edge.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  datapath fetch byte address; bits [1:0] are ignored.
- ihit  out  1  requested word is valid on imemload this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; data is valid when iREN=1 and iwait=0.
- iload  in  32  memory read data.

Behaviour:
- Address split, low to high:
  - byte offset: 2 bits.
  - word offset: log2(BLKWORDS) bits.
  - index: log2(SETS) bits.
  - tag: the remaining bits (26 at defaults).
- Storage per way per set: valid bit, tag, BLKWORDS data words.
- Storage per set: LRU state.
  - WAYS=2: one bit naming the next victim.
  - WAYS=4: tree pseudo-LRU, 3 bits.
  - WAYS=1: no LRU state.
- Reset (nRST=0 at an edge): all valid bits, LRU state, word counter and latched address go to 0; FSM goes to IDLE.
- Output values while nRST is low, or in the cycle after reset: ihit=0, iREN=0, iaddr=0, imemload=0.
- Reset asserted mid-refill aborts the refill; the partial block is discarded and no way is written.
- FSM states:
  - IDLE: lookup is combinational.
    - Hit = imemREN and some way in the indexed set is valid with a matching tag.
    - On a hit: ihit=1 in the same cycle, imemload = the selected word of the hit way, iREN=0. At the edge, LRU is updated to mark the hit way most-recently-used.
    - On a miss (imemREN=1, no hit): ihit=0. At the edge, latch the block-aligned address, clear the word counter and go to REFILL. iREN stays 0 in the miss cycle.
    - imemREN=0: ihit=0, iREN=0, no state change.
  - REFILL:
    - iREN=1, iaddr = latched block base + 4*counter.
    - On each edge with iwait=0: store iload into the line buffer at the counter position and increment the counter.
    - When the last word is accepted (counter = BLKWORDS-1 and iwait=0):
      - victim way = first invalid way (lowest index); otherwise the LRU way.
      - Write the buffer into that way; set valid and tag.
      - Mark the victim most-recently-used.
      - Go to IDLE.
  - Refill latency: the next IDLE-cycle lookup of the same address hits, with zero extra cycles.
  - ihit=0 throughout REFILL, even if the current imemaddr would hit elsewhere.
  - The refill completes even if imemREN drops or imemaddr changes mid-refill; the new address is looked up in IDLE afterwards.
  - iwait held high stalls indefinitely with iREN and iaddr stable.
- imemload value when ihit=0: don't-care, but it must not be X after reset. Drive way 0's selected word.
- Tag compare must never produce hits in multiple ways. Only a refill installs a line, and it only installs after a miss, so duplicates cannot occur. An assertion checks this.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count (out, 32) and miss_count (out, 32). Both reset to 0.
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE to REFILL transition.
  - Both wrap at 2^32.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, imemREN=1, addr 0x0000_0040, iwait=0 -> miss.
  - REFILL issues iaddr 0x40 then 0x44.
  - The next cycle gives ihit=1 with imemload = the word returned for 0x40.
  - A later read of 0x44 hits immediately.
- Defaults, two tags in set 0 (0x000, 0x040), then a third (0x080) -> 0x080 evicts 0x000.
  - LRU victim is 0x000 because 0x040 was touched last.
  - Re-reading 0x040 hits; 0x000 misses.
- iwait held high for 5 cycles during REFILL -> iREN=1 and iaddr constant throughout; no data stored until iwait=0.
- imemaddr changes from 0x40 to 0x100 mid-refill -> the block at 0x40 still completes and installs; then 0x100 misses and refills.
- nRST=0 for one cycle mid-refill -> state IDLE, all lines invalid; the original address misses again afterwards.
- With ICACHE_STATS_EN, run 3 misses and 5 hits -> miss_count=3, hit_count=5.
